interlaced_frame_buffer: RTL and testbench

//  Single-clock 320x240 RGB888 frame store between camera/pixel-stream producer and VGA reader.

---
 rtl/fb_pkg.sv | 50 +++++
 rtl/fb_field_ram.sv | 26 ++
 rtl/interlaced_frame_buffer.sv | 101 ++++++++++
 tb/tb_interlaced_frame_buffer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and constants for the interlaced 320x240 RGB888 frame store.
// Address helpers keep the row/col <-> field-address arithmetic in one place.
package fb_pkg;

    localparam int H_ACTIVE     = 320;
    localparam int V_ACTIVE     = 240;
    localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
    localparam int FIELD_WORDS  = FRAME_PIXELS / 2;
    localparam int PIXEL_W      = 24;
    localparam int ADDR_W       = 17;
    localparam int BANK_AW      = 16;
    localparam int COL_W        = 9;
    localparam int ROW_W        = 8;

    typedef logic [PIXEL_W-1:0] pixel_t;
    typedef logic [ADDR_W-1:0]  lin_addr_t;
    typedef logic [BANK_AW-1:0] bank_addr_t;

    typedef struct packed {
        logic [8:0]       row;
        logic [COL_W-1:0] col;
        logic             oor;
    } rd_s1_t;

    typedef struct packed {
        bank_addr_t baddr;
        logic       bank;
        logic       oor;
    } rd_s2_t;

    // addr/320 == (addr/64)/5; 13108/65536 is exact for every addr>>6 below 2048
    function automatic logic [8:0] div320(input logic [10:0] a_hi);
        return 9'((25'(a_hi) * 25'd13108) >> 16);
    endfunction

    function automatic logic [COL_W-1:0] col_of(input lin_addr_t a,
                                                input logic [8:0] row);
        lin_addr_t r;
        r = lin_addr_t'(row);
        return COL_W'(a - ((r << 8) + (r << 6)));
    endfunction

    function automatic bank_addr_t field_addr(input logic [ROW_W-1:0] row_half,
                                              input logic [COL_W-1:0] col);
        bank_addr_t r;
        r = bank_addr_t'(row_half);
        return (r << 8) + (r << 6) + bank_addr_t'(col);
    endfunction

endpackage

// File: rtl/fb_field_ram.sv
// One field of the frame store: simple dual-port, read-first, registered read.
// No reset on the array or the read register so it maps onto block RAM.
module fb_field_ram
    import fb_pkg::*;
(
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [BANK_AW-1:0] waddr_i,
    input  logic [PIXEL_W-1:0] wdata_i,
    input  logic [BANK_AW-1:0] raddr_i,
    output logic [PIXEL_W-1:0] rdata_o
);

    pixel_t mem_q [FIELD_WORDS];
    pixel_t rdata_q;

    always_ff @(posedge clk_i) begin
        rdata_q <= mem_q[raddr_i];
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/interlaced_frame_buffer.sv
// 320x240 RGB888 frame store: raster write pointer, 3-stage linear-address read.
// Even rows live in one field RAM, odd rows in the other.
module interlaced_frame_buffer
    import fb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  read_addr,
    input  logic [PIXEL_W-1:0] pixel_in,
    output logic [PIXEL_W-1:0] pixel_out
);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    rd_s1_t           s1_q, s1_d;
    rd_s2_t           s2_q, s2_d;
    logic             s3_bank_q;
    logic             s3_oor_q;
    pixel_t           pix_q, pix_d;

    bank_addr_t waddr;
    logic       we_even;
    logic       we_odd;
    pixel_t     rd_even;
    pixel_t     rd_odd;

    always_comb begin
        col_d = col_q + 1'b1;
        row_d = row_q;
        if (col_q == COL_W'(H_ACTIVE - 1)) begin
            col_d = '0;
            row_d = (row_q == ROW_W'(V_ACTIVE - 1)) ? '0 : row_q + 1'b1;
        end
    end

    assign waddr   = field_addr({1'b0, row_q[ROW_W-1:1]}, col_q);
    assign we_even = reset & ~row_q[0];
    assign we_odd  = reset & row_q[0];

    always_comb begin
        s1_d     = '0;
        s1_d.row = div320(read_addr[16:6]);
        s1_d.col = col_of(read_addr, s1_d.row);
        s1_d.oor = (read_addr >= ADDR_W'(FRAME_PIXELS));
    end

    always_comb begin
        s2_d       = '0;
        s2_d.baddr = field_addr(s1_q.row[8:1], s1_q.col);
        s2_d.bank  = s1_q.row[0];
        s2_d.oor   = s1_q.oor;
    end

    always_comb begin
        pix_d = '0;
        if (!s3_oor_q) begin
            pix_d = s3_bank_q ? rd_odd : rd_even;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q     <= '0;
            row_q     <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            s3_bank_q <= 1'b0;
            s3_oor_q  <= 1'b0;
            pix_q     <= '0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_bank_q <= s2_q.bank;
            s3_oor_q  <= s2_q.oor;
            pix_q     <= pix_d;
        end
    end

    fb_field_ram u_even (
        .clk_i   (clk),
        .we_i    (we_even),
        .waddr_i (waddr),
        .wdata_i (pixel_in),
        .raddr_i (s2_q.baddr),
        .rdata_o (rd_even)
    );

    fb_field_ram u_odd (
        .clk_i   (clk),
        .we_i    (we_odd),
        .waddr_i (waddr),
        .wdata_i (pixel_in),
        .raddr_i (s2_q.baddr),
        .rdata_o (rd_odd)
    );

    assign pixel_out = pix_q;

endmodule

// File: tb/tb_interlaced_frame_buffer.sv
// Scoreboard bench for interlaced_frame_buffer: bars frame, parity/divide,
// out-of-range, read-first collision and mid-frame reset retention.
module tb_interlaced_frame_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [16:0] read_addr = '0;
    logic [23:0] pixel_in = '0;
    logic [23:0] pixel_out;

    interlaced_frame_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .read_addr (read_addr),
        .pixel_in  (pixel_in),
        .pixel_out (pixel_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          addr;
        logic [23:0] exp;
    } exp_t;

    exp_t        sb[$];
    logic [23:0] mem [76800];
    int          wp = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          p_chk = 0;
    int          p_addr = 0;

    task automatic check(input string name, input logic [23:0] act,
                         input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] bar(input int a);
        if (a < 25600) return 24'hFF0000;
        if (a < 51200) return 24'h00FF00;
        return 24'h0000FF;
    endfunction

    function automatic logic [23:0] f1(input int a);
        if (a == 319 || a == 320 || a == 639 || a == 640 ||
            a == 38399 || a == 38400 || a == 76799)
            return 24'(a);
        return bar(a);
    endfunction

    function automatic logic [23:0] f2(input int a);
        return 24'hA00000 | 24'(a);
    endfunction

    function automatic logic [23:0] f3(input int a);
        return 24'h5A0000 | 24'(a);
    endfunction

    // read schedule during frame 2, keyed by the write pointer
    function automatic int sched2(input int a);
        case (a)
            0: return 76796;   1: return 76797;
            2: return 76798;   3: return 76799;
            4: return 76800;   5: return 131071;
            6: return 319;     7: return 320;
            8: return 639;     9: return 640;
            10: return 0;      11: return 38399;
            12: return 38400;  13: return 51199;
            14: return 51200;  15: return 25599;
            16: return 25600;  17: return 5;
            298: return 300;   299: return 301;
            310: return 300;   398: return 400;
            399: return 400;   1500: return 1000;
            1501: return 1999;
            default: return -1;
        endcase
    endfunction

    function automatic int sched3(input int a);
        case (a)
            150: return 0;     151: return 100;
            152: return 199;   153: return 200;
            154: return 1999;  155: return 2000;
            156: return 40000; 157: return 76799;
            158: return 51200; 159: return 39999;
            default: return -1;
        endcase
    endfunction

    task automatic step(input bit rst, input logic [23:0] pix,
                        input int ra, input bit chk);
        exp_t e;
        reset     = rst;
        pixel_in  = pix;
        read_addr = 17'(ra);
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            mem[wp] = pix;
            wp = (wp + 1) % 76800;
            if (p_chk) begin
                e.due  = cyc + 2;
                e.addr = p_addr;
                e.exp  = (p_addr >= 76800) ? 24'h0 : mem[p_addr];
                sb.push_back(e);
            end
        end else begin
            wp = 0;
        end
        p_chk  = chk && rst;
        p_addr = ra;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("reset_out", pixel_out, 24'h0);
        end
        if (sb.size() > 0) begin
            if (sb[0].due == cyc) begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("rd[%0d]", e.addr), pixel_out, e.exp);
            end else if (sb[0].due < cyc) begin
                exp_t e;
                e = sb.pop_front();
                errors++;
                checks++;
                $display("FAIL missed rd[%0d]: due %0d now %0d",
                         e.addr, e.due, cyc);
            end
        end
    end

    initial begin
        repeat (10) step(1'b0, 24'h0, 0, 1'b0);

        for (int a = 0; a < 76800; a++) begin
            if (a >= 4) step(1'b1, f1(a), a - 4, 1'b1);
            else        step(1'b1, f1(a), 0, 1'b0);
            if (a == 0) check("first_word_even0", dut.u_even.mem_q[0], 24'hFF0000);
        end
        check("even_bank_640", dut.u_even.mem_q[320], 24'd640);
        check("odd_bank_320", dut.u_odd.mem_q[0], 24'd320);
        check("odd_bank_last", dut.u_odd.mem_q[38399], 24'd76799);

        for (int a = 0; a < 2000; a++) begin
            int r;
            r = sched2(a);
            if (r >= 0) step(1'b1, f2(a), r, 1'b1);
            else        step(1'b1, f2(a), 0, 1'b0);
        end

        repeat (3) step(1'b0, 24'hDEAD00, 0, 1'b0);

        for (int a = 0; a < 200; a++) begin
            int r;
            r = sched3(a);
            if (r >= 0) step(1'b1, f3(a), r, 1'b1);
            else        step(1'b1, f3(a), 0, 1'b0);
        end
        repeat (10) step(1'b1, 24'h0, 0, 1'b0);

        if (sb.size() != 0) begin
            errors += sb.size();
            checks += sb.size();
            $display("FAIL drain: %0d reads never observed, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
